// File: rtl/instr_fetch.sv
// instr_fetch: initiator side of the 16-bit instruction ROM read port; owns the PC and presents fetched words with a valid/ready handshake.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin or resume fetching (used only in IDLE or HALTED)
//   rom_read, rom_addr     ROM read strobe and address (rom_addr is the PC)
//   rom_data               ROM word, valid the cycle after rom_read
//   instr_valid, instr_ready  handshake towards the decode/execute stage
//   jump_en, jump_addr     PC redirect, used only on an accept cycle
//   instr, opcode, dst, src   instruction register and its fields
//   instr_pc               address the current instruction came from
//   halted                 fetching stopped after a NOP
module instr_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter bit         HALT_ON_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_read,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [5:0]  dst,
  output logic [5:0]  src,
  output logic [7:0]  instr_pc,
  output logic        halted
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] CAPT   = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  instr_pc_q, instr_pc_d;
  logic [15:0] instr_q, instr_d;
  logic        accept, halt_nop;

  always_comb begin
    accept     = (state_q == HOLD) & instr_ready;
    halt_nop   = HALT_ON_NOP & (instr_q[15:12] == 4'b0000);
    state_d    = (state_q == IDLE || state_q == HALTED) ? (start ? REQ : state_q) :
                 (state_q == REQ)  ? CAPT :
                 (state_q == CAPT) ? HOLD :
                 (state_q == HOLD) ? (accept ? (halt_nop ? HALTED : REQ) : HOLD) :
                 IDLE;
    // A jump on the halting accept still retargets the PC, so a later start resumes there.
    pc_d       = (state_q == CAPT) ? pc_q + 8'd1 :
                 (accept & jump_en) ? jump_addr : pc_q;
    instr_d    = (state_q == CAPT) ? rom_data : instr_q;
    instr_pc_d = (state_q == CAPT) ? pc_q : instr_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign rom_read    = state_q == REQ;
  assign instr_valid = state_q == HOLD;
  assign halted      = state_q == HALTED;
  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = instr_q[15:12];
  assign dst         = instr_q[11:6];
  assign src         = instr_q[5:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch (default params and RESET_PC=FF/HALT_ON_NOP=0).
module tb_instr_fetch;
  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [256];
  exp_t q_a[$];
  exp_t q_b[$];
  int vectors = 0;
  int miscompares = 0;

  logic        a_rst_n, a_start, a_rd, a_valid, a_ready, a_jen, a_halted;
  logic [7:0]  a_addr, a_jaddr, a_ipc;
  logic [15:0] a_rdata, a_instr;
  logic [3:0]  a_op;
  logic [5:0]  a_dst, a_src;

  logic        b_rst_n, b_start, b_rd, b_valid, b_ready, b_jen, b_halted;
  logic [7:0]  b_addr, b_jaddr, b_ipc;
  logic [15:0] b_rdata, b_instr;
  logic [3:0]  b_op;
  logic [5:0]  b_dst, b_src;

  instr_fetch dut_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start), .rom_read(a_rd), .rom_addr(a_addr),
    .rom_data(a_rdata), .instr_valid(a_valid), .instr_ready(a_ready), .jump_en(a_jen),
    .jump_addr(a_jaddr), .instr(a_instr), .opcode(a_op), .dst(a_dst), .src(a_src),
    .instr_pc(a_ipc), .halted(a_halted)
  );

  instr_fetch #(.RESET_PC(8'hFF), .HALT_ON_NOP(1'b0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .rom_read(b_rd), .rom_addr(b_addr),
    .rom_data(b_rdata), .instr_valid(b_valid), .instr_ready(b_ready), .jump_en(b_jen),
    .jump_addr(b_jaddr), .instr(b_instr), .opcode(b_op), .dst(b_dst), .src(b_src),
    .instr_pc(b_ipc), .halted(b_halted)
  );

  always_ff @(posedge clk) begin
    if (a_rd) a_rdata <= rom[a_addr];
    if (b_rd) b_rdata <= rom[b_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!a_valid && n < 20) begin
      tick();
      n++;
    end
    chk("a_wait_valid", {31'd0, a_valid}, 32'd1);
  endtask

  task automatic accept_a(input logic j, input logic [7:0] ad);
    a_ready = 1'b1;
    a_jen   = j;
    a_jaddr = ad;
    tick();
    a_ready = 1'b0;
    a_jen   = 1'b0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (a_valid && a_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_word", {16'd0, a_instr}, 32'hFFFF_FFFF);
      else begin
        e = q_a.pop_front();
        chk("a_instr", {16'd0, a_instr}, {16'd0, e.w});
        chk("a_opcode", {28'd0, a_op}, {28'd0, e.w[15:12]});
        chk("a_dst", {26'd0, a_dst}, {26'd0, e.w[11:6]});
        chk("a_src", {26'd0, a_src}, {26'd0, e.w[5:0]});
        chk("a_instr_pc", {24'd0, a_ipc}, {24'd0, e.pc});
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b_valid && b_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_word", {16'd0, b_instr}, 32'hFFFF_FFFF);
      else begin
        e = q_b.pop_front();
        chk("b_instr", {16'd0, b_instr}, {16'd0, e.w});
        chk("b_instr_pc", {24'd0, b_ipc}, {24'd0, e.pc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'hE0, i[7:0]};
    rom[8'h00] = 16'h1042;
    rom[8'h01] = 16'h2103;
    rom[8'h02] = 16'h3085;
    rom[8'h0B] = 16'hC04F;
    rom[8'h0C] = 16'h7186;
    rom[8'h0D] = 16'h0123;
    rom[8'h0E] = 16'h4ABC;
    rom[8'hFF] = 16'h0FFF;
    a_rst_n = 0; a_start = 0; a_ready = 0; a_jen = 0; a_jaddr = 0;
    b_rst_n = 0; b_start = 0; b_ready = 0; b_jen = 0; b_jaddr = 0;
    tick(3);
    chk("rst_addr", {24'd0, a_addr}, 32'h00);
    chk("rst_rd", {31'd0, a_rd}, 32'd0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_halted", {31'd0, a_halted}, 32'd0);
    chk("rst_instr", {16'd0, a_instr}, 32'h0);
    chk("rst_fields", {16'd0, a_op, a_dst, a_src}, 32'h0);
    chk("rst_ipc", {24'd0, a_ipc}, 32'h0);
    chk("rst_addr_b", {24'd0, b_addr}, 32'hFF);
    a_rst_n = 1;
    b_rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_read", {31'd0, a_rd}, 32'd0);
    end
    // Sequential fetch with ready high; third word is then held by backpressure.
    q_a.push_back('{16'h1042, 8'h00});
    q_a.push_back('{16'h2103, 8'h01});
    q_a.push_back('{16'h3085, 8'h02});
    a_ready = 1;
    a_start = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) a_start = 0;
      chk("seq_valid", {31'd0, a_valid}, (k % 3 == 0) ? 32'd1 : 32'd0);
      chk("seq_read", {31'd0, a_rd}, (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k == 9) a_ready = 0;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_instr", {16'd0, a_instr}, 32'h3085);
      chk("bp_ipc", {24'd0, a_ipc}, 32'h02);
      chk("bp_valid", {31'd0, a_valid}, 32'd1);
      chk("bp_read", {31'd0, a_rd}, 32'd0);
    end
    a_ready = 1;
    tick();
    a_ready = 0;
    chk("post_accept_read", {31'd0, a_rd}, 32'd1);
    chk("post_accept_addr", {24'd0, a_addr}, 32'h03);
    chk("post_accept_valid", {31'd0, a_valid}, 32'd0);
    // Jump from 0x01 to 0x0B, run to the NOP at 0x0D, halt, resume at 0x0E.
    a_rst_n = 0;
    #1;
    chk("async_rst_instr_a", {16'd0, a_instr}, 32'h0);
    tick();
    a_rst_n = 1;
    q_a.push_back('{16'h1042, 8'h00});
    q_a.push_back('{16'h2103, 8'h01});
    q_a.push_back('{16'hC04F, 8'h0B});
    q_a.push_back('{16'h7186, 8'h0C});
    q_a.push_back('{16'h0123, 8'h0D});
    q_a.push_back('{16'h4ABC, 8'h0E});
    a_start = 1;
    tick();
    a_start = 0;
    wait_valid_a();
    accept_a(1'b0, 8'h00);
    wait_valid_a();
    chk("jmp_src_pc", {24'd0, a_ipc}, 32'h01);
    accept_a(1'b1, 8'h0B);
    chk("jmp_read", {31'd0, a_rd}, 32'd1);
    chk("jmp_addr", {24'd0, a_addr}, 32'h0B);
    wait_valid_a();
    chk("jmp_instr", {16'd0, a_instr}, 32'hC04F);
    chk("jmp_fields", {16'd0, a_op, a_dst, a_src}, {16'd0, 4'hC, 6'd1, 6'd15});
    accept_a(1'b0, 8'h00);
    wait_valid_a();
    accept_a(1'b0, 8'h00);
    wait_valid_a();
    chk("nop_opcode", {28'd0, a_op}, 32'h0);
    accept_a(1'b0, 8'h00);
    chk("halt_halted", {31'd0, a_halted}, 32'd1);
    chk("halt_valid", {31'd0, a_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_no_read", {31'd0, a_rd}, 32'd0);
      chk("halt_stays", {31'd0, a_halted}, 32'd1);
    end
    a_start = 1;
    tick();
    a_start = 0;
    chk("resume_read", {31'd0, a_rd}, 32'd1);
    chk("resume_addr", {24'd0, a_addr}, 32'h0E);
    chk("resume_halted", {31'd0, a_halted}, 32'd0);
    wait_valid_a();
    accept_a(1'b0, 8'h00);
    // Second instance: wrap FF->00, NOP at FF does not halt.
    q_b.push_back('{16'h0FFF, 8'hFF});
    q_b.push_back('{16'h1042, 8'h00});
    b_ready = 1;
    b_start = 1;
    tick();
    b_start = 0;
    chk("wrap_first_addr", {24'd0, b_addr}, 32'hFF);
    chk("wrap_first_read", {31'd0, b_rd}, 32'd1);
    tick(3);
    chk("nohalt_halted", {31'd0, b_halted}, 32'd0);
    chk("wrap_read", {31'd0, b_rd}, 32'd1);
    chk("wrap_addr", {24'd0, b_addr}, 32'h00);
    tick(3);
    b_ready = 0;
    chk("nohalt_continue_read", {31'd0, b_rd}, 32'd1);
    chk("nohalt_continue_addr", {24'd0, b_addr}, 32'h01);
    chk("nohalt_halted2", {31'd0, b_halted}, 32'd0);
    // Async reset while in CAPT.
    b_rst_n = 0;
    tick();
    b_rst_n = 1;
    b_start = 1;
    tick();
    b_start = 0;
    tick();
    chk("capt_read", {31'd0, b_rd}, 32'd0);
    chk("capt_valid", {31'd0, b_valid}, 32'd0);
    #2;
    b_rst_n = 0;
    #1;
    chk("arst_instr", {16'd0, b_instr}, 32'h0);
    chk("arst_addr", {24'd0, b_addr}, 32'hFF);
    chk("arst_ipc", {24'd0, b_ipc}, 32'h0);
    chk("arst_read", {31'd0, b_rd}, 32'd0);
    chk("arst_valid", {31'd0, b_valid}, 32'd0);
    chk("arst_halted", {31'd0, b_halted}, 32'd0);
    tick();
    b_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_idle_read", {31'd0, b_rd}, 32'd0);
      chk("arst_idle_valid", {31'd0, b_valid}, 32'd0);
      chk("arst_idle_instr", {16'd0, b_instr}, 32'h0);
    end
    b_start = 1;
    tick();
    b_start = 0;
    chk("arst_restart_addr", {24'd0, b_addr}, 32'hFF);
    chk("arst_restart_read", {31'd0, b_rd}, 32'd1);
    tick(2);
    chk("queue_a_empty", q_a.size(), 32'd0);
    chk("queue_b_empty", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
